// File: rtl/dco_bank_ctrl_if.sv
// Tuning-word valid/ready bus between the loop filter
// and one DCO bank controller.
interface dco_bank_ctrl_if #(
    parameter int TW_W = 13
);
    logic            tw_valid;
    logic            tw_ready;
    logic [TW_W-1:0] tw;

    modport master (
        output tw_valid,
        output tw,
        input  tw_ready
    );

    modport slave (
        input  tw_valid,
        input  tw,
        output tw_ready
    );
endinterface

// File: rtl/dco_bank_ctrl.sv
// Tuning-word controller for one ROWSxCOLS DCO capacitor bank:
// slew limiting, sigma-delta dither and row/column select decode.
module dco_bank_ctrl #(
    parameter int ROWS   = 16,
    parameter int COLS   = 16,
    parameter int FRAC_W = 4,
    parameter int STEP   = 8,
    localparam int NCELL = ROWS * COLS,
    localparam int CW    = $clog2(NCELL + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    dco_bank_ctrl_if.slave   tw_bus,
    output logic [ROWS-1:0]  o_row_all,
    output logic [ROWS-1:0]  o_row_sel,
    output logic [COLS-1:0]  o_col_en,
    output logic [CW-1:0]    o_cnt,
    output logic             o_settled
);

    localparam int LC = $clog2(COLS);
    localparam logic [CW-1:0] NCELL_C = CW'(NCELL);
    localparam logic [CW-1:0] STEP_C  = CW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_RAMP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     r_tgt;
    logic [FRAC_W-1:0] r_frac;
    logic [FRAC_W-1:0] r_acc;
    logic [ROWS-1:0]   r_row_all;
    logic [ROWS-1:0]   r_row_sel;
    logic [COLS-1:0]   r_col_en;
    logic              r_settled;

    logic              w_ready;
    logic              w_dith;
    logic              w_upd;
    logic              w_xfer;
    logic [CW-1:0]     w_tw_int;
    logic [CW-1:0]     w_tw_clamp;
    logic [CW-1:0]     w_diff;
    logic [CW-1:0]     w_stp;
    logic [CW-1:0]     w_cnt_step;
    logic [FRAC_W:0]   w_sum;
    logic              w_carry;
    logic [CW:0]       w_n_raw;
    logic [CW-1:0]     w_n;
    logic [CW-1:0]     w_f;
    logic [LC-1:0]     w_r;
    logic [ROWS-1:0]   w_row_all;
    logic [ROWS-1:0]   w_row_sel;
    logic [COLS-1:0]   w_col_en;

    assign w_tw_int   = tw_bus.tw[CW+FRAC_W-1:FRAC_W];
    assign w_tw_clamp = (w_tw_int > NCELL_C) ? NCELL_C : w_tw_int;
    assign w_xfer     = tw_bus.tw_valid & w_ready;

    // Slew step: move by at most STEP, never past the target
    assign w_diff     = (r_tgt > r_cnt) ? (r_tgt - r_cnt) : (r_cnt - r_tgt);
    assign w_stp      = (w_diff > STEP_C) ? STEP_C : w_diff;
    assign w_cnt_step = (r_tgt > r_cnt) ? (r_cnt + w_stp) : (r_cnt - w_stp);

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_frac};
    assign w_carry = w_dith & w_sum[FRAC_W];
    assign w_n_raw = {1'b0, r_cnt} + {{CW{1'b0}}, w_carry};
    assign w_n     = (w_n_raw > {1'b0, NCELL_C}) ? NCELL_C : w_n_raw[CW-1:0];

    assign w_f = w_n >> LC;
    assign w_r = w_n[LC-1:0];

    always_comb begin
        w_row_all = '0;
        w_row_sel = '0;
        w_col_en  = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_row_all[r] = (CW'(r) < w_f);
            w_row_sel[r] = (w_r != '0) && (w_f == CW'(r));
        end
        for (int c = 0; c < COLS; c++) begin
            w_col_en[c] = (LC'(c) < w_r);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  w_state_nxt = S_TRACK;
                S_TRACK: begin
                    if (w_xfer && (i_mode != 2'd0) && (w_tw_clamp != r_cnt))
                        w_state_nxt = S_RAMP;
                end
                S_RAMP: begin
                    if (w_cnt_step == r_tgt)
                        w_state_nxt = S_TRACK;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready = i_en & (r_state == S_TRACK);
        w_dith  = i_en & (r_state == S_TRACK) & (i_mode == 2'd2);
        w_upd   = i_en & (r_state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_tgt     <= '0;
            r_frac    <= '0;
            r_acc     <= '0;
            r_row_all <= '0;
            r_row_sel <= '0;
            r_col_en  <= '0;
            r_settled <= 1'b0;
        end else begin
            r_acc <= w_dith ? w_sum[FRAC_W-1:0] : '0;
            // Leaving IDLE re-anchors the target to wherever the count stopped
            if (r_state == S_IDLE) begin
                if (i_en)
                    r_tgt <= r_cnt;
            end else if (w_upd) begin
                if (w_xfer) begin
                    r_tgt  <= w_tw_clamp;
                    r_frac <= tw_bus.tw[FRAC_W-1:0];
                end
                if (r_state == S_RAMP)
                    r_cnt <= w_cnt_step;
                else if (r_cnt != r_tgt)
                    r_cnt <= r_tgt;
                r_row_all <= w_row_all;
                r_row_sel <= w_row_sel;
                r_col_en  <= w_col_en;
                r_settled <= (r_state != S_RAMP) && (r_cnt == r_tgt);
            end
        end
    end

    assign tw_bus.tw_ready = w_ready;
    assign o_row_all       = r_row_all;
    assign o_row_sel       = r_row_sel;
    assign o_col_en        = r_col_en;
    assign o_cnt           = r_cnt;
    assign o_settled       = r_settled;

endmodule

// File: tb/tb_dco_bank_ctrl.sv
// Self-checking bench for dco_bank_ctrl (16x16 bank, STEP=8,
// FRAC_W=4) against a count-level reference model.
module tb_dco_bank_ctrl;

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int FW    = 4;
    localparam int STEP  = 8;
    localparam int NCELL = ROWS * COLS;
    localparam int CW    = $clog2(NCELL + 1);
    localparam int TWW   = CW + FW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [ROWS-1:0] row_all;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_en;
    logic [CW-1:0]   cnt;
    logic            settled;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_cnt  = 0;

    dco_bank_ctrl_if #(.TW_W(TWW)) bus ();

    dco_bank_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .FRAC_W(FW), .STEP(STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (en),
        .i_mode    (mode),
        .tw_bus    (bus.slave),
        .o_row_all (row_all),
        .o_row_sel (row_sel),
        .o_col_en  (col_en),
        .o_cnt     (cnt),
        .o_settled (settled)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    function automatic int clampi(input int v);
        return (v > NCELL) ? NCELL : v;
    endfunction

    function automatic int cells();
        int n;
        n = $countones(row_all) * COLS;
        if (row_sel != '0) n += $countones(col_en);
        return n;
    endfunction

    function automatic logic [ROWS-1:0] exp_ra(input int n);
        logic [ROWS:0] t;
        t = (ROWS+1)'(1) << (n / COLS);
        return ROWS'(t - 1);
    endfunction

    function automatic logic [ROWS-1:0] exp_rs(input int n);
        logic [ROWS:0] t;
        t = (ROWS+1)'(1) << (n / COLS);
        return ((n % COLS) != 0) ? ROWS'(t) : '0;
    endfunction

    function automatic logic [COLS-1:0] exp_ce(input int n);
        logic [COLS:0] t;
        t = (COLS+1)'(1) << (n % COLS);
        return COLS'(t - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int iv, input int fv, input int md);
        int w;
        w = 0;
        mode = 2'(md);
        bus.tw = TWW'((iv << FW) | fv);
        bus.tw_valid = 1'b1;
        while (!bus.tw_ready && w < 50) begin
            tick();
            w++;
        end
        n_cmp++;
        if (bus.tw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL xfer_ready: got %0b want 1", bus.tw_ready);
        end
        tick();
        bus.tw_valid = 1'b0;
    endtask

    task automatic ramp_check(input int v, input int fv, input int md);
        int q[$];
        int c, t, d, s;
        t = clampi(v);
        c = m_cnt;
        if (md == 0) begin
            if (t != c) q.push_back(t);
        end else begin
            while (c != t) begin
                d = (t > c) ? t - c : c - t;
                s = (d < STEP) ? d : STEP;
                c = (t > c) ? c + s : c - s;
                q.push_back(c);
            end
        end
        xfer(v, fv, md);
        if (q.size() == 0) begin
            tick();
            n_cmp++;
            if (cnt !== CW'(t) || settled !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp_none: cnt=%0d settled=%0b want %0d/1",
                         cnt, settled, t);
            end
        end else begin
            foreach (q[j]) begin
                tick();
                n_cmp++;
                if (cnt !== CW'(q[j])) begin
                    n_fail++;
                    $display("FAIL ramp_step%0d: cnt=%0d want %0d", j, cnt, q[j]);
                end
                n_cmp++;
                if (bus.tw_ready !== (j == q.size() - 1)) begin
                    n_fail++;
                    $display("FAIL ramp_ready%0d: got %0b", j, bus.tw_ready);
                end
            end
            n_cmp++;
            if (settled !== 1'b0) begin
                n_fail++;
                $display("FAIL ramp_settle_early: got %0b want 0", settled);
            end
            tick();
            n_cmp++;
            if (settled !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp_settled: got %0b want 1", settled);
            end
        end
        m_cnt = t;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tw_valid = 1'b0;
        bus.tw = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        en = 1'b1;
        tick();
        xfer(37, 0, 0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (cnt !== '0 || row_all !== '0 || row_sel !== '0 ||
            col_en !== '0 || settled !== 1'b0 || bus.tw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: cnt=%0d ra=%h rs=%h ce=%h st=%0b rdy=%0b want all 0",
                     cnt, row_all, row_sel, col_en, settled, bus.tw_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.tw_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_idle: got %0b want 0", bus.tw_ready);
        end
        tick();
        n_cmp++;
        if (bus.tw_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_track: got %0b want 1", bus.tw_ready);
        end
        m_cnt = 0;
    endtask

    task automatic test_direct();
        int v;
        xfer(37, 0, 0);
        tick();
        n_cmp++;
        if (cnt !== CW'(37)) begin
            n_fail++;
            $display("FAIL direct37_cnt: got %0d want 37", cnt);
        end
        tick();
        n_cmp++;
        if (row_all !== 16'h0003 || row_sel !== 16'h0004 ||
            col_en !== 16'h001F || settled !== 1'b1) begin
            n_fail++;
            $display("FAIL direct37_dec: ra=%h rs=%h ce=%h st=%0b want 0003/0004/001f/1",
                     row_all, row_sel, col_en, settled);
        end
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 16 : int'($urandom_range(0, NCELL));
            xfer(v, 0, 0);
            tick();
            n_cmp++;
            if (cnt !== CW'(v)) begin
                n_fail++;
                $display("FAIL direct_cnt: got %0d want %0d", cnt, v);
            end
            tick();
            n_cmp++;
            if (row_all !== exp_ra(v) || row_sel !== exp_rs(v) ||
                col_en !== exp_ce(v) || settled !== 1'b1) begin
                n_fail++;
                $display("FAIL direct_dec n=%0d: ra=%h rs=%h ce=%h st=%0b want %h/%h/%h/1",
                         v, row_all, row_sel, col_en, settled,
                         exp_ra(v), exp_rs(v), exp_ce(v));
            end
        end
        m_cnt = v;
    endtask

    task automatic test_back_to_back();
        int a, b;
        a = int'($urandom_range(0, 127));
        b = int'($urandom_range(128, NCELL));
        xfer(a, 0, 0);
        xfer(b, 0, 0);
        n_cmp++;
        if (cnt !== CW'(a)) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d want %0d", cnt, a);
        end
        tick();
        n_cmp++;
        if (cnt !== CW'(b)) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d want %0d", cnt, b);
        end
        tick();
        m_cnt = b;
    endtask

    task automatic test_slew();
        int v, md;
        xfer(0, 0, 0);
        tick();
        tick();
        m_cnt = 0;
        ramp_check(37, 0, 1);
        ramp_check(5, 0, 3);
        for (int i = 0; i < 6; i++) begin
            v = int'($urandom_range(0, 300));
            md = int'($urandom_range(0, 3));
            ramp_check(v, 0, md);
        end
    endtask

    task automatic test_sat();
        int v;
        xfer(300, 0, 0);
        tick();
        n_cmp++;
        if (cnt !== CW'(NCELL)) begin
            n_fail++;
            $display("FAIL sat_cnt: got %0d want %0d", cnt, NCELL);
        end
        tick();
        n_cmp++;
        if (row_all !== 16'hFFFF || row_sel !== '0 || col_en !== '0) begin
            n_fail++;
            $display("FAIL sat_dec: ra=%h rs=%h ce=%h want ffff/0000/0000",
                     row_all, row_sel, col_en);
        end
        m_cnt = NCELL;
        v = int'($urandom_range(NCELL + 1, 511));
        ramp_check(v, 0, 1);
    endtask

    task automatic test_dither();
        int f, hits, bad, n;
        ramp_check(100, 4, 2);
        for (int k = 0; k < 4; k++) begin
            f = (k == 0) ? 4 : int'($urandom_range(1, 15));
            if (k > 0) xfer(100, f, 2);
            tick();
            tick();
            tick();
            hits = 0;
            bad = 0;
            for (int i = 0; i < 16; i++) begin
                n = cells();
                if (n == 101) hits++;
                else if (n != 100) bad++;
                if (cnt !== CW'(100)) bad++;
                tick();
            end
            n_cmp++;
            if (hits != f || bad != 0) begin
                n_fail++;
                $display("FAIL dither_f%0d: hits=%0d bad=%0d want %0d/0", f, hits, bad, f);
            end
        end
        mode = 2'd1;
        tick();
        tick();
        n_cmp++;
        if (cells() != 100) begin
            n_fail++;
            $display("FAIL dither_off: cells=%0d want 100", cells());
        end
        ramp_check(NCELL, 9, 2);
        tick();
        tick();
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (cells() != NCELL) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dither_full: %0d samples off %0d", bad, NCELL);
        end
    endtask

    task automatic test_en_drop();
        xfer(0, 0, 0);
        tick();
        tick();
        m_cnt = 0;
        xfer(37, 0, 1);
        tick();
        tick();
        n_cmp++;
        if (cnt !== CW'(16)) begin
            n_fail++;
            $display("FAIL endrop_pre: cnt=%0d want 16", cnt);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (cnt !== CW'(16) || bus.tw_ready !== 1'b0 || settled !== 1'b0) begin
                n_fail++;
                $display("FAIL endrop_hold%0d: cnt=%0d rdy=%0b st=%0b want 16/0/0",
                         i, cnt, bus.tw_ready, settled);
            end
        end
        en = 1'b1;
        m_cnt = 16;
        ramp_check(37, 0, 1);
    endtask

    initial begin
        test_reset();
        test_direct();
        test_back_to_back();
        test_slew();
        test_sat();
        test_dither();
        test_en_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
